// File: rtl/axil_gpio_if.sv
// AXI4-Lite bus bundle for the GPIO peripheral: master drives requests, slave drives ready/response.
interface axil_gpio_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_gpio_slave.sv
// AXI4-Lite GPIO slave: data/dir/scratch registers, synchronized pin capture.
// Optional edge interrupt (IER/ISR, irq) built only when AXIL_GPIO_IRQ_EN is defined.
module axil_gpio_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int GPIO_WIDTH         = 32,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    axil_gpio_if.slave            s_axi,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_t,
    output logic                  irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [DW-1:0] GPIO_MASK =
        (GPIO_WIDTH >= DW) ? {DW{1'b1}} : DW'((64'd1 << GPIO_WIDTH) - 64'd1);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic          awready_q, wready_q, bvalid_q;
    logic          arready_q, rvalid_q;
    logic [DW-1:0] rdata_q;
    logic          aw_held, w_held;
    logic [2:0]    awslot_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    wstrb_q;

    logic [DW-1:0] data_out, dir, scratch0, scratch1;
    logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_WIDTH-1:0] data_in;
    logic [DW-1:0]         data_in_w;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [2:0]    wr_slot;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
    logic [DW-1:0] rd_val;

    logic unused_ok;
    assign unused_ok = ^{1'b0, s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [3:0]    strb);
        logic [DW-1:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++)
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign aw_hs = s_axi.awvalid & awready_q;
    assign w_hs  = s_axi.wvalid & wready_q;
    assign ar_hs = s_axi.arvalid & arready_q;

    // A held channel takes precedence; otherwise use the one handshaking this cycle.
    assign wr_slot = aw_held ? awslot_q : s_axi.awaddr[4:2];
    assign wr_data = w_held ? wdata_q : s_axi.wdata;
    assign wr_strb = w_held ? wstrb_q : s_axi.wstrb;
    assign commit  = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awslot_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state   <= W_RESP;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_held   <= 1'b1;
                            awslot_q  <= s_axi.awaddr[4:2];
                            awready_q <= 1'b0;
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            wdata_q  <= s_axi.wdata;
                            wstrb_q  <= s_axi.wstrb;
                            wready_q <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        w_state   <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign data_in   = sync_q[SYNC_STAGES-1];
    assign data_in_w = DW'(data_in);

`ifdef AXIL_GPIO_IRQ_EN
    logic [DW-1:0]         ier, isr, isr_clr, isr_set;
    logic [GPIO_WIDTH-1:0] data_in_d;
    logic                  irq_q;

    assign isr_clr = (commit && wr_slot == 3'd6) ? merge('0, wr_data, wr_strb) : '0;
    assign isr_set = DW'(data_in & ~data_in_d);

    // Set is ORed after the clear so a same-cycle rising edge wins.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            isr       <= '0;
            data_in_d <= '0;
            irq_q     <= 1'b0;
        end else begin
            isr       <= ((isr & ~isr_clr) | isr_set) & GPIO_MASK;
            data_in_d <= data_in;
            irq_q     <= |(isr & ier);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            data_out <= '0;
            dir      <= '0;
            scratch0 <= '0;
            scratch1 <= '0;
`ifdef AXIL_GPIO_IRQ_EN
            ier      <= '0;
`endif
        end else if (commit) begin
            case (wr_slot)
                3'd0: data_out <= merge(data_out, wr_data, wr_strb) & GPIO_MASK;
                3'd1: dir      <= merge(dir, wr_data, wr_strb) & GPIO_MASK;
                3'd2: scratch0 <= merge(scratch0, wr_data, wr_strb);
                3'd3: scratch1 <= merge(scratch1, wr_data, wr_strb);
`ifdef AXIL_GPIO_IRQ_EN
                3'd5: ier      <= merge(ier, wr_data, wr_strb) & GPIO_MASK;
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (s_axi.araddr[4:2])
            3'd0: rd_val = data_out;
            3'd1: rd_val = dir;
            3'd2: rd_val = scratch0;
            3'd3: rd_val = scratch1;
            3'd4: rd_val = data_in_w;
`ifdef AXIL_GPIO_IRQ_EN
            3'd5: rd_val = ier;
            3'd6: rd_val = isr;
`endif
            default: rd_val = '0;
        endcase
    end

    // Registers update non-blocking, so a same-edge write is not seen by this read.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state   <= R_RESP;
                        rdata_q   <= rd_val;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        r_state   <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign gpio_o = data_out[GPIO_WIDTH-1:0];
    assign gpio_t = ~dir[GPIO_WIDTH-1:0];
endmodule

// File: tb/tb_axil_gpio_slave.sv
// Directed bench for axil_gpio_slave: register table plus handshake, sync, irq and reset sequences.
module tb_axil_gpio_slave;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    axil_gpio_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o, gpio_t;
    logic        irq;

    axil_gpio_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .GPIO_WIDTH(32),
        .SYNC_STAGES(2)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .s_axi(bus.slave),
        .gpio_i(gpio_i),
        .gpio_o(gpio_o),
        .gpio_t(gpio_t),
        .irq(irq)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        bit          pins;
        logic [31:0] exp_o;
        logic [31:0] exp_t;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        @(negedge ACLK);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        n = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge ACLK);
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.wvalid = 1'b0;  w_done = 1;  end
            n++;
        end
        chk("wr_accept", 32'(aw_done && w_done), 32'd1);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid_seen", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        @(negedge ACLK);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit ar_hs, done;
        @(negedge ACLK);
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0; done = 0;
        while (!done && n < 50) begin
            ar_hs = bus.arvalid && bus.arready;
            @(negedge ACLK);
            if (ar_hs) begin bus.arvalid = 1'b0; done = 1; end
            n++;
        end
        chk("rd_accept", 32'(done), 32'd1);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge ACLK); n++; end
        chk("rvalid_seen", 32'(bus.rvalid), 32'd1);
        d = bus.rdata; resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge ACLK);
        bus.rready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;
        logic [31:0] exp_ier;
        bit          hold_ok;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

`ifdef AXIL_GPIO_IRQ_EN
        exp_ier = 32'hFFFF_FFFF;
`else
        exp_ier = 32'h0;
`endif

        //          wr addr   data           strb  exp            pins exp_o          exp_t
        vecs.push_back('{1, 5'h00, 32'h0000_0001, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h04, 32'h0000_0002, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h08, 32'h0000_0003, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h00, 32'h0,         4'h0, 32'h0000_0001, 1, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{0, 5'h04, 32'h0,         4'h0, 32'h0000_0002, 0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h08, 32'h0,         4'h0, 32'h0000_0003, 0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h0C, 32'h0,         4'h0, 32'h0000_0004, 0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h00, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h00, 32'h1234_5678, 4'h5, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h00, 32'h0,         4'h0, 32'hFF34_FF78, 1, 32'hFF34_FF78, 32'hFFFF_FFFD});
        vecs.push_back('{1, 5'h1C, 32'hDEAD_BEEF, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h1C, 32'h0,         4'h0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h10, 32'h0,         4'h0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h0B, 32'h0,         4'h0, 32'h0000_0003, 0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h08, 32'hFFFF_FFFF, 4'h0, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h08, 32'h0,         4'h0, 32'h0000_0003, 0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h04, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h04, 32'h0,         4'h0, 32'hFFFF_FFFF, 1, 32'hFF34_FF78, 32'h0});
        vecs.push_back('{1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 32'h0,         32'h0});
        vecs.push_back('{0, 5'h14, 32'h0,         4'h0, exp_ier,       0, 32'h0,         32'h0});
        vecs.push_back('{1, 5'h14, 32'h0,         4'hF, 32'h0,         0, 32'h0,         32'h0});

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_wready",  32'(bus.wready),  32'd1);
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
        chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
        chk("rst_rdata",   bus.rdata,        32'h0);
        chk("rst_gpio_o",  gpio_o,           32'h0);
        chk("rst_gpio_t",  gpio_t,           32'hFFFF_FFFF);
        chk("rst_irq",     32'(irq),         32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                chk($sformatf("vec%0d_bresp", i), 32'(rsp), 32'd0);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
                chk($sformatf("vec%0d_rresp", i), 32'(rsp), 32'd0);
            end
            if (vecs[i].pins) begin
                chk($sformatf("vec%0d_gpio_o", i), gpio_o, vecs[i].exp_o);
                chk($sformatf("vec%0d_gpio_t", i), gpio_t, vecs[i].exp_t);
            end
        end

        // AW first, W four cycles later; BVALID the cycle after W handshake, then BREADY held low
        @(negedge ACLK);
        bus.awaddr = 5'h08; bus.awvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        chk("awfirst_awready_low", 32'(bus.awready), 32'd0);
        repeat (3) @(negedge ACLK);
        chk("awfirst_no_bvalid", 32'(bus.bvalid), 32'd0);
        chk("awfirst_wready_hi", 32'(bus.wready), 32'd1);
        bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        chk("awfirst_bvalid", 32'(bus.bvalid), 32'd1);
        hold_ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            if (!(bus.bvalid && !bus.awready && !bus.wready)) hold_ok = 0;
        end
        chk("bvalid_hold_5", 32'(hold_ok), 32'd1);
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
        chk("b_done_bvalid", 32'(bus.bvalid), 32'd0);
        chk("b_done_ready", 32'({bus.awready, bus.wready}), 32'd3);
        axi_read(5'h08, rd, rsp);
        chk("awfirst_readback", rd, 32'hA5A5_A5A5);

        // W first, AW later
        @(negedge ACLK);
        bus.wdata = 32'h5A5A_5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("wfirst_no_bvalid", 32'(bus.bvalid), 32'd0);
        bus.awaddr = 5'h08; bus.awvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        chk("wfirst_bvalid", 32'(bus.bvalid), 32'd1);
        bus.bready = 1'b1;
        @(negedge ACLK);
        bus.bready = 1'b0;
        axi_read(5'h08, rd, rsp);
        chk("wfirst_readback", rd, 32'h5A5A_5A5A);

        // Read and write hit SCRATCH1 on the same edge; read sees old value, RDATA held while RREADY low
        @(negedge ACLK);
        bus.araddr = 5'h0C; bus.arvalid = 1'b1;
        bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
        bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("coll_rvalid", 32'(bus.rvalid), 32'd1);
        chk("coll_bvalid", 32'(bus.bvalid), 32'd1);
        chk("coll_rdata_old", bus.rdata, 32'h0000_0004);
        hold_ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            if (!(bus.rvalid && !bus.arready && bus.rdata == 32'h0000_0004)) hold_ok = 0;
        end
        chk("rvalid_hold_5", 32'(hold_ok), 32'd1);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(negedge ACLK);
        bus.rready = 1'b0; bus.bready = 1'b0;
        chk("r_done_arready", 32'(bus.arready), 32'd1);
        axi_read(5'h0C, rd, rsp);
        chk("coll_readback_new", rd, 32'hCAFE_F00D);

        // Input synchronizer and interrupt
        axi_write(5'h14, 32'h0000_0010, 4'hF, rsp);
        @(negedge ACLK);
        gpio_i = 32'h0000_00F0;
        repeat (2) @(negedge ACLK);
        axi_read(5'h10, rd, rsp);
        chk("data_in_sync", rd, 32'h0000_00F0);
        repeat (2) @(negedge ACLK);
`ifdef AXIL_GPIO_IRQ_EN
        chk("irq_set", 32'(irq), 32'd1);
        axi_read(5'h18, rd, rsp);
        chk("isr_edges", rd, 32'h0000_00F0);
        axi_write(5'h18, 32'h0000_0010, 4'hF, rsp);
        repeat (2) @(negedge ACLK);
        chk("irq_cleared", 32'(irq), 32'd0);
        axi_read(5'h18, rd, rsp);
        chk("isr_w1c", rd, 32'h0000_00E0);
`else
        chk("irq_tied_low", 32'(irq), 32'd0);
        axi_read(5'h18, rd, rsp);
        chk("isr_absent", rd, 32'h0);
`endif

        // Reset with BVALID pending
        @(negedge ACLK);
        bus.awaddr = 5'h00; bus.awvalid = 1'b1;
        bus.wdata = 32'h0000_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
        #1 ARESETN = 1'b0;
        #1;
        chk("async_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("async_rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'd7);
        chk("async_rst_gpio_o", gpio_o, 32'h0);
        chk("async_rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        chk("async_rst_irq", 32'(irq), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        axi_read(5'h00, rd, rsp);
        chk("post_rst_data_out", rd, 32'h0);
        axi_read(5'h0C, rd, rsp);
        chk("post_rst_scratch1", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
